urv_tb_mem_ctrl: RTL and testbench
==================================

Name: urv_tb_mem_ctrl

Overview:
- Synthesizable, parametrised memory/peripheral model for the uRV CPU: instruction fetch port, data port, byte-lane stores and a memory-mapped console TX FIFO.
- Replaces ad-hoc behavioural memory in benches and FPGA smoke builds.
- Adds configurable load wait-states, load/store done handshakes, console back-pressure and optional pseudo-random fetch stalls.

Parameters:
- g_MEM_WORDS, 16384, RAM depth in 32-bit words; power of 2, >= 256.
- g_LOAD_WAIT, 0, extra wait cycles before a load completes; 0..15.
- g_CON_ADDR, 32'h0010_0000, byte address of the console TX register.
- g_CON_FIFO_DEPTH, 16, console FIFO entries; power of 2, 2..256.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, synchronous, active-low
- im_addr_i  in  32  fetch byte address
- im_data_o  out  32  fetched word
- im_valid_o  out  1  im_data_o valid
- dm_addr_i  in  32  data byte address
- dm_data_s_i  in  32  store data
- dm_data_select_i  in  4  byte enables
- dm_store_i  in  1  store request
- dm_load_i  in  1  load request
- dm_data_l_o  out  32  load data
- dm_store_done_o  out  1  store accepted, 1-cycle pulse
- dm_load_done_o  out  1  load data valid, 1-cycle pulse
- dm_ready_o  out  1  data port can accept a request
- con_data_o  out  8  console FIFO head byte
- con_valid_o  out  1  FIFO not empty
- con_ready_i  in  1  consumer pops head when con_valid_o and con_ready_i are both high

Behaviour:
- Clock and reset: one clock, clk_i; reset is synchronous and active-low (rst_n_i).
- Reset values:
  - All outputs 0 except dm_ready_o, which is 1 from the first cycle after reset.
  - FIFO empty; FSM in IDLE.
  - RAM contents are not cleared.
- Word index: (addr >> 2) mod g_MEM_WORDS; addresses wrap silently. dm_addr_i[1:0] is ignored.
- Fetch port:
  - Registered read, 1-cycle latency: im_data_o = RAM[im_addr_i in cycle N] in cycle N+1.
  - im_valid_o = 1 every cycle out of reset (feature off).
- Data FSM:
  - IDLE, dm_store_i, RAM address: lanes with dm_data_select_i[k]=1 written at the edge. dm_store_done_o pulses in the next cycle. Stay IDLE, dm_ready_o=1.
  - IDLE, dm_store_i, dm_addr_i == g_CON_ADDR:
    - FIFO not full: push dm_data_s_i[7:0]; store_done pulses next cycle.
    - FIFO full: go to CON_BLOCK, dm_ready_o=0, request latched. Byte is pushed on the first cycle space exists, then store_done pulses and FSM returns to IDLE.
  - IDLE, dm_load_i:
    - Latch address and go to LOAD_WAIT; counter = g_LOAD_WAIT; dm_ready_o=0.
    - Counter decrements each cycle; at 0, go to LOAD_DONE. With g_LOAD_WAIT=0, LOAD_DONE follows directly.
    - LOAD_DONE: dm_data_l_o = RAM word read at the LOAD_WAIT→DONE edge; dm_load_done_o=1 for exactly one cycle; then IDLE.
    - Total latency from request to done = g_LOAD_WAIT+1 cycles.
  - Load from g_CON_ADDR returns a status word:
    - bit0 = FIFO full
    - bit1 = FIFO empty
    - bits[15:8] = FIFO level
    - all other bits 0
  - dm_load_i and dm_store_i both high: store wins, load ignored, no load_done.
  - Requests while dm_ready_o=0 are ignored.
  - dm_data_l_o holds its last value outside LOAD_DONE.
- Console FIFO:
  - Push and pop in the same cycle when full: both occur; level unchanged.
  - Pop when empty: no effect.
  - con_data_o is combinational from the head entry.
- Reset mid-operation: FSM → IDLE, pending load/store dropped (no done pulse), FIFO flushed, partial RAM writes already made are kept.

Optional Feature:
- Macro: URV_MEM_IM_STALL_EN.
- Defined:
  - 16-bit Galois LFSR (poly 0xB400, reset seed 0xACE1) steps every cycle.
  - When lfsr[2:0]==0, im_valid_o=0 and im_data_o holds its previous value; the fetch is not performed that cycle.
- Undefined: LFSR is absent and im_valid_o=1 constantly after reset.

Test Plan:
- Fetch: preload RAM[5]=0x1234_5678, im_addr_i=0x14 → im_data_o=0x1234_5678 and im_valid_o=1 the next cycle. im_addr_i=0x14+4*g_MEM_WORDS → same word (wrap).
- Byte store then load: RAM[0x40]=0xFFFF_FFFF; store 0xAABB_CCDD to 0x100 with select 4'b0101 → load 0x100 returns 0xFFBB_FFDD. With g_LOAD_WAIT=3, dm_load_done_o rises exactly 4 cycles after dm_load_i; dm_ready_o is low for those 4 cycles.
- Console back-pressure: depth 4, con_ready_i=0, five stores 'a'..'e' to 0x100000 → fifth stalls (dm_ready_o=0, no store_done). Status load is blocked until the stall clears. Raise con_ready_i → bytes 'a','b','c','d','e' drain in order; the fifth store_done pulses one cycle after the first pop. Final status load = 0x0000_0002.
- Simultaneous load+store to 0x200: store lands, no load_done pulse.
- Reset mid-load: g_LOAD_WAIT=5, rst_n_i low for 1 cycle during LOAD_WAIT → no load_done, dm_ready_o=1 next cycle, RAM intact.
- With URV_MEM_IM_STALL_EN: over 8000 cycles, im_valid_o low in 12.5% ±1% of cycles. Every im_valid_o=1 cycle carries the correct word for the address presented the previous cycle.

Source files
------------

// File: rtl/urv_tb_mem_ctrl.sv
// Synthesizable memory/peripheral model for the uRV CPU: fetch port, data port, and console TX FIFO.
// Optional pseudo-random fetch stalls are enabled by defining URV_MEM_IM_STALL_EN.
module urv_tb_mem_ctrl #(
    parameter int          g_MEM_WORDS      = 16384,
    parameter int          g_LOAD_WAIT      = 0,
    parameter logic [31:0] g_CON_ADDR       = 32'h0010_0000,
    parameter int          g_CON_FIFO_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] im_addr_i,
    output logic [31:0] im_data_o,
    output logic        im_valid_o,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_store_done_o,
    output logic        dm_load_done_o,
    output logic        dm_ready_o,
    output logic [7:0]  con_data_o,
    output logic        con_valid_o,
    input  logic        con_ready_i
);

    localparam int AW = $clog2(g_MEM_WORDS);
    localparam int FW = $clog2(g_CON_FIFO_DEPTH);
    localparam int CW = FW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_WAIT,
        S_LOAD_DONE,
        S_CON_BLOCK
    } state_t;

    logic [31:0]   mem_q [g_MEM_WORDS];
    logic [AW-1:0] im_idx;
    logic [AW-1:0] dm_idx;
    logic          dm_is_con;

    assign im_idx    = im_addr_i[AW+1:2];
    assign dm_idx    = dm_addr_i[AW+1:2];
    assign dm_is_con = (dm_addr_i[31:2] == g_CON_ADDR[31:2]);

    state_t        state_q;
    logic          ready_q;
    logic          store_done_q;
    logic          load_done_q;
    logic [31:0]   data_l_q;
    logic [3:0]    wait_cnt_q;
    logic [AW-1:0] ld_idx_q;
    logic          ld_con_q;
    logic [7:0]    con_byte_q;

    logic [7:0]    fifo_q [g_CON_FIFO_DEPTH];
    logic [FW-1:0] head_q;
    logic [FW-1:0] tail_q;
    logic [CW-1:0] level_q;
    logic [CW-1:0] level_d;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop_w;
    logic          push_w;
    logic          space_w;
    logic [7:0]    push_byte;
    logic [8:0]    level_ext;
    logic [31:0]   status_w;

    logic          idle_w;
    logic          ram_we;

    assign fifo_full  = (level_q == CW'(g_CON_FIFO_DEPTH));
    assign fifo_empty = (level_q == '0);
    assign pop_w      = con_ready_i & ~fifo_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a byte.
    assign space_w    = ~fifo_full | pop_w;

    assign idle_w    = (state_q == S_IDLE);
    assign ram_we    = rst_n_i & idle_w & dm_store_i & ~dm_is_con;
    assign push_w    = rst_n_i & space_w &
                       ((idle_w & dm_store_i & dm_is_con) | (state_q == S_CON_BLOCK));
    assign push_byte = (state_q == S_CON_BLOCK) ? con_byte_q : dm_data_s_i[7:0];

    assign level_ext = 9'(level_q);
    assign status_w  = {16'h0000, level_ext[7:0], 6'b000000, fifo_empty, fifo_full};

    always_comb begin
        level_d = level_q + CW'(push_w) - CW'(pop_w);
    end

    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            for (int k = 0; k < 4; k++) begin
                if (dm_data_select_i[k]) begin
                    mem_q[dm_idx][8*k +: 8] <= dm_data_s_i[8*k +: 8];
                end
            end
        end
    end

`ifdef URV_MEM_IM_STALL_EN
    logic [15:0] lfsr_q;
    logic        fetch_en;

    assign fetch_en = (lfsr_q[2:0] != 3'b000);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end
`else
    logic fetch_en;

    assign fetch_en = 1'b1;
`endif

    logic [31:0] im_data_q;
    logic        im_valid_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            im_data_q  <= 32'h0;
            im_valid_q <= 1'b0;
        end else begin
            im_valid_q <= fetch_en;
            if (fetch_en) begin
                im_data_q <= mem_q[im_idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_w) begin
                tail_q <= tail_q + FW'(1);
            end
            if (pop_w) begin
                head_q <= head_q + FW'(1);
            end
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_w) begin
            fifo_q[tail_q] <= push_byte;
        end
    end

    // Data-port FSM; the done pulses and the ready flag are registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b1;
            store_done_q <= 1'b0;
            load_done_q  <= 1'b0;
            data_l_q     <= 32'h0;
            wait_cnt_q   <= 4'h0;
            ld_idx_q     <= '0;
            ld_con_q     <= 1'b0;
            con_byte_q   <= 8'h00;
        end else begin
            store_done_q <= 1'b0;
            load_done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (dm_store_i) begin
                        if (!dm_is_con || space_w) begin
                            store_done_q <= 1'b1;
                        end else begin
                            state_q    <= S_CON_BLOCK;
                            ready_q    <= 1'b0;
                            con_byte_q <= dm_data_s_i[7:0];
                        end
                    end else if (dm_load_i) begin
                        ready_q  <= 1'b0;
                        ld_idx_q <= dm_idx;
                        ld_con_q <= dm_is_con;
                        if (g_LOAD_WAIT == 0) begin
                            data_l_q    <= dm_is_con ? status_w : mem_q[dm_idx];
                            load_done_q <= 1'b1;
                            state_q     <= S_LOAD_DONE;
                        end else begin
                            wait_cnt_q <= 4'(g_LOAD_WAIT - 1);
                            state_q    <= S_LOAD_WAIT;
                        end
                    end
                end
                S_LOAD_WAIT: begin
                    if (wait_cnt_q == 4'h0) begin
                        data_l_q    <= ld_con_q ? status_w : mem_q[ld_idx_q];
                        load_done_q <= 1'b1;
                        state_q     <= S_LOAD_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'h1;
                    end
                end
                S_LOAD_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_CON_BLOCK: begin
                    if (space_w) begin
                        store_done_q <= 1'b1;
                        ready_q      <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign im_data_o       = im_data_q;
    assign im_valid_o      = im_valid_q;
    assign dm_data_l_o     = data_l_q;
    assign dm_store_done_o = store_done_q;
    assign dm_load_done_o  = load_done_q;
    assign dm_ready_o      = ready_q;
    assign con_valid_o     = ~fifo_empty;
    assign con_data_o      = fifo_empty ? 8'h00 : fifo_q[head_q];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{im_addr_i[1:0], im_addr_i[31:AW+2], dm_addr_i[1:0], level_ext[8]};

endmodule

// File: tb/tb_urv_tb_mem_ctrl.sv
// Self-checking bench for urv_tb_mem_ctrl: directed scenarios plus a randomized phase
// checked against a transaction-level memory/FIFO model.
module tb_urv_tb_mem_ctrl;

    localparam int          MW    = 256;
    localparam int          AW    = 8;
    localparam int          LW    = 3;
    localparam int          DEPTH = 4;
    localparam logic [31:0] CON   = 32'h0010_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic        im_valid;
    logic [31:0] dm_addr;
    logic [31:0] dm_data_s;
    logic [3:0]  dm_sel;
    logic        dm_store;
    logic        dm_load;
    logic [31:0] dm_data_l;
    logic        dm_store_done;
    logic        dm_load_done;
    logic        dm_ready;
    logic [7:0]  con_data;
    logic        con_valid;
    logic        con_ready;

    urv_tb_mem_ctrl #(
        .g_MEM_WORDS     (MW),
        .g_LOAD_WAIT     (LW),
        .g_CON_ADDR      (CON),
        .g_CON_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .im_addr_i       (im_addr),
        .im_data_o       (im_data),
        .im_valid_o      (im_valid),
        .dm_addr_i       (dm_addr),
        .dm_data_s_i     (dm_data_s),
        .dm_data_select_i(dm_sel),
        .dm_store_i      (dm_store),
        .dm_load_i       (dm_load),
        .dm_data_l_o     (dm_data_l),
        .dm_store_done_o (dm_store_done),
        .dm_load_done_o  (dm_load_done),
        .dm_ready_o      (dm_ready),
        .con_data_o      (con_data),
        .con_valid_o     (con_valid),
        .con_ready_i     (con_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_m [MW];
    bit          known [MW];
    logic [7:0]  q [$];
    bit          rand_ready;
    bit          rand_fetch;
    logic [31:0] exp_im;
    bit          exp_im_known;
    int          stalls = 0;
    int          run_cycles = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    function automatic bit is_con(input logic [31:0] a);
        return a[31:2] == CON[31:2];
    endfunction

    function automatic logic [31:0] status_m();
        logic [31:0] s;
        s       = 32'h0;
        s[0]    = (q.size() == DEPTH);
        s[1]    = (q.size() == 0);
        s[15:8] = 8'(q.size());
        return s;
    endfunction

    // One clock: checks console outputs now, fetch result after the edge, and updates pops.
    task automatic tick();
        bit          r;
        bit          pop;
        logic [31:0] fexp;
        bit          fknown;
        logic [AW-1:0] fi;
        r   = rst_n;
        pop = r && con_ready && (q.size() > 0);
        chk1("con_valid", con_valid, q.size() > 0);
        if (q.size() > 0) chk("con_data", 32'(con_data), 32'(q[0]));
        else              chk("con_data_empty", 32'(con_data), 32'h0);
        fi     = im_addr[AW+1:2];
        fexp   = mem_m[fi];
        fknown = known[fi];
        @(posedge clk);
        #1;
        if (!r) begin
            q.delete();
            exp_im       = 32'h0;
            exp_im_known = 1'b1;
            chk1("im_valid_rst", im_valid, 1'b0);
            chk("im_data_rst", im_data, 32'h0);
        end else begin
            if (pop) void'(q.pop_front());
            run_cycles++;
`ifdef URV_MEM_IM_STALL_EN
            if (im_valid === 1'b1) begin
                exp_im       = fexp;
                exp_im_known = fknown;
                if (fknown) chk("im_data", im_data, fexp);
            end else begin
                stalls++;
                chk1("im_valid_defined", im_valid, 1'b0);
                if (exp_im_known) chk("im_data_hold", im_data, exp_im);
            end
`else
            chk1("im_valid", im_valid, 1'b1);
            if (fknown) chk("im_data", im_data, fexp);
`endif
        end
        if (rand_ready) con_ready = 1'($urandom_range(0, 1));
        if (rand_fetch) im_addr = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            chk1("idle_store_done", dm_store_done, 1'b0);
            chk1("idle_load_done", dm_load_done, 1'b0);
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel,
                            input bit with_load, input int release_after);
        bit            con;
        bit            space;
        bit            done_b;
        logic [AW-1:0] wi;
        con = is_con(a);
        wi  = a[AW+1:2];
        chk1("store_pre_ready", dm_ready, 1'b1);
        dm_addr   = a;
        dm_data_s = d;
        dm_sel    = sel;
        dm_store  = 1'b1;
        dm_load   = with_load;
        space     = (q.size() < DEPTH) || (con_ready && q.size() > 0);
        tick();
        dm_store = 1'b0;
        dm_load  = 1'b0;
        if (!con) begin
            for (int k = 0; k < 4; k++)
                if (sel[k]) mem_m[wi][8*k +: 8] = d[8*k +: 8];
            if (sel == 4'hF) known[wi] = 1'b1;
        end else if (space) begin
            q.push_back(d[7:0]);
        end
        if (con && !space) begin
            done_b = 1'b0;
            for (int i = 0; i < 200; i++) begin
                chk1("blocked_store_done", dm_store_done, 1'b0);
                chk1("blocked_ready", dm_ready, 1'b0);
                if (i == release_after) con_ready = 1'b1;
                space   = (q.size() < DEPTH) || (con_ready && q.size() > 0);
                dm_load = !space;
                tick();
                dm_load = 1'b0;
                if (space) begin
                    q.push_back(d[7:0]);
                    done_b = 1'b1;
                    break;
                end
            end
            chk1("blocked_store_timeout", done_b, 1'b1);
        end
        chk1("store_done", dm_store_done, 1'b1);
        chk1("store_ready", dm_ready, 1'b1);
    endtask

    task automatic do_load(input logic [31:0] a, output logic [31:0] obs);
        logic [31:0] exp;
        exp = 32'h0;
        chk1("load_pre_ready", dm_ready, 1'b1);
        dm_addr = a;
        dm_load = 1'b1;
        for (int i = 0; i <= LW; i++) begin
            if (i == LW) exp = is_con(a) ? status_m() : mem_m[a[AW+1:2]];
            tick();
            dm_load = 1'b0;
            if (i < LW) begin
                chk1("load_wait_done", dm_load_done, 1'b0);
                chk1("load_wait_ready", dm_ready, 1'b0);
            end
        end
        chk1("load_done", dm_load_done, 1'b1);
        chk1("load_done_ready", dm_ready, 1'b0);
        chk("load_data", dm_data_l, exp);
        obs = dm_data_l;
        tick();
        chk1("load_done_pulse", dm_load_done, 1'b0);
        chk1("load_post_ready", dm_ready, 1'b1);
        chk("load_data_hold", dm_data_l, exp);
    endtask

    task automatic fetch_check(input logic [31:0] a, input logic [31:0] exp, input string tag);
        rand_fetch = 1'b0;
        im_addr    = a;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (im_valid === 1'b1) break;
        end
        chk1({tag, "_valid"}, im_valid, 1'b1);
        chk(tag, im_data, exp);
        rand_fetch = 1'b1;
    endtask

    initial begin
        logic [31:0] obs;
        int          r;
        logic [31:0] a;
        rst_n = 1'b0; im_addr = 32'h0; dm_addr = 32'h0; dm_data_s = 32'h0; dm_sel = 4'h0;
        dm_store = 1'b0; dm_load = 1'b0; con_ready = 1'b0;
        rand_ready = 1'b0; rand_fetch = 1'b0; exp_im = 32'h0; exp_im_known = 1'b1;
        for (int i = 0; i < MW; i++) begin mem_m[i] = 32'h0; known[i] = 1'b0; end
        repeat (2) @(posedge clk);
        #1;
        tick();
        chk1("rst_ready", dm_ready, 1'b1);
        chk1("rst_store_done", dm_store_done, 1'b0);
        chk1("rst_load_done", dm_load_done, 1'b0);
        chk("rst_data_l", dm_data_l, 32'h0);
        chk1("rst_con_valid", con_valid, 1'b0);
        chk("rst_con_data", 32'(con_data), 32'h0);
        rst_n = 1'b1;
        tick();

        rand_fetch = 1'b1;
        for (int i = 0; i < MW; i++) do_store(32'(i * 4), $urandom, 4'hF, 1'b0, 0);
        idle(1);

        do_store(32'h100, 32'hFFFF_FFFF, 4'hF, 1'b0, 0);
        do_store(32'h100, 32'hAABB_CCDD, 4'b0101, 1'b0, 0);
        do_load(32'h100, obs);
        chk("byte_lane_load", obs, 32'hFFBB_FFDD);

        do_store(32'h14, 32'h1234_5678, 4'hF, 1'b0, 0);
        fetch_check(32'h14, 32'h1234_5678, "fetch_word5");
        fetch_check(32'h14 + 32'(4 * MW), 32'h1234_5678, "fetch_wrap");

        con_ready = 1'b0;
        do_store(CON, 32'h61, 4'h1, 1'b0, 0);
        do_store(CON, 32'h62, 4'h1, 1'b0, 0);
        do_store(CON, 32'h63, 4'h1, 1'b0, 0);
        do_store(CON, 32'h64, 4'h1, 1'b0, 0);
        do_load(CON, obs);
        chk("status_full", obs, 32'h0000_0401);
        do_store(CON, 32'h65, 4'h1, 1'b0, 3);
        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
        chk("fifo_drained", 32'(q.size()), 32'h0);
        idle(2);
        con_ready = 1'b0;
        do_load(CON, obs);
        chk("status_empty", obs, 32'h0000_0002);

        do_store(32'h200, 32'h5A5A_1234, 4'hF, 1'b1, 0);
        idle(LW + 3);
        do_load(32'h200, obs);
        chk("load_store_collide", obs, 32'h5A5A_1234);

        do_store(CON, 32'h71, 4'h1, 1'b0, 0);
        do_store(CON, 32'h72, 4'h1, 1'b0, 0);
        dm_addr = 32'h100;
        dm_load = 1'b1;
        tick();
        dm_load = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk1("midrst_ready", dm_ready, 1'b1);
        chk1("midrst_load_done", dm_load_done, 1'b0);
        chk("midrst_data_l", dm_data_l, 32'h0);
        chk1("midrst_con_valid", con_valid, 1'b0);
        idle(LW + 3);
        do_load(32'h100, obs);
        chk("midrst_ram_kept", obs, 32'hFFBB_FFDD);

        rand_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 9));
            a = (r % 2 == 0) ? $urandom : {22'h0, 8'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if (r <= 3)      do_store(a, $urandom, 4'($urandom_range(0, 15)), r == 3, 1000);
            else if (r <= 5) do_store(CON, $urandom, 4'h1, 1'b0, 1000);
            else if (r <= 8) do_load(a, obs);
            else             do_load(CON, obs);
            idle(1);
        end
        rand_ready = 1'b0;
        con_ready  = 1'b1;

        run_cycles = 0;
        stalls     = 0;
        for (int n = 0; n < 8000; n++) tick();
`ifdef URV_MEM_IM_STALL_EN
        chk1("stall_ratio", (stalls * 1000 >= run_cycles * 115) && (stalls * 1000 <= run_cycles * 135), 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
